instr_encoder: RTL and testbench

Packs decoded RISC-V instruction fields into 32-bit instruction words. Its opcode-to-format mapping is the inverse of the core's instruction decoder ImmSrc mapping. Used by the self-test/boot path to synthesize program words, which are streamed into instruction memory over a valid/ready interface. Illegal or unencodable requests are consumed, flagged and counted, and never emitted.

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs RISC-V instruction fields into 32-bit words and streams them out through a small FIFO.
// Requests that cannot be encoded are dropped, flagged with an error code and counted.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] emit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

    fmt_t        fmt;
    logic        is_shift;
    logic        sext_11;
    logic        sext_12;
    logic        sext_20;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  code;
    logic [31:0] word;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic accept;
    logic push;
    logic pop;

    // Upper immediate bits must all match the sign bit of the encodable field.
    assign sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext_20 = (&imm[31:20]) | ~(|imm[31:20]);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        fmt          = FMT_BAD;
        is_shift     = 1'b0;
        misalign     = 1'b0;
        out_of_range = 1'b0;
        word         = '0;
        code         = ERR_NONE;

        case (op)
            7'b0110011:                         fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b1101111:                         fmt = FMT_J;
            7'b0010111:                         fmt = FMT_U;
            default:                            fmt = FMT_BAD;
        endcase

        is_shift = (op == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));

        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, op};
            FMT_I: begin
                if (is_shift) begin
                    word         = {funct7, imm[4:0], rs1, funct3, rd, op};
                    out_of_range = |imm[31:5];
                end else begin
                    word         = {imm[11:0], rs1, funct3, rd, op};
                    out_of_range = !sext_11;
                end
            end
            FMT_S: begin
                word         = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                out_of_range = !sext_11;
            end
            FMT_B: begin
                word         = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                misalign     = imm[0];
                out_of_range = !sext_12;
            end
            FMT_J: begin
                word         = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                misalign     = imm[0];
                out_of_range = !sext_20;
            end
            FMT_U: begin
                word         = {imm[31:12], rd, op};
                out_of_range = |imm[11:0];
            end
            default: word = '0;
        endcase

        if (fmt == FMT_BAD) begin
            code = ERR_OPCODE;
        end else if (misalign) begin
            code = ERR_MISALIGN;
        end else if (out_of_range) begin
            code = ERR_RANGE;
        end
    end

    assign in_ready  = (occ < OCC_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : '0;

    assign accept = in_valid & in_ready;
    assign push   = accept & (code == ERR_NONE);
    assign pop    = out_valid & out_ready;

    // NOTE: buffer storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
            emit_count <= '0;
            err_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            err_valid <= accept & (code != ERR_NONE);
            if (accept && (code != ERR_NONE)) begin
                err_code <= code;
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end

            if (pop && (emit_count != '1)) begin
                emit_count <= emit_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus randomized requests checked
// against an arithmetic reference model of the RISC-V field packing and legality rules.
module tb_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err_valid;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] emit_count;
    logic [CNT_W-1:0] err_count;

    logic rand_ready  = 1'b0;
    logic rnd_ready   = 1'b1;
    logic fixed_ready = 1'b1;
    assign out_ready = rand_ready ? rnd_ready : fixed_ready;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .emit_count (emit_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic [1:0]  err_q [$];
    int          model_emit = 0;
    int          model_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: legality from signed ranges, word from shifted field arithmetic.
    function automatic void model(input logic [6:0] m_op, input logic [4:0] m_rd,
                                  input logic [4:0] m_rs1, input logic [4:0] m_rs2,
                                  input logic [2:0] m_f3, input logic [6:0] m_f7,
                                  input logic [31:0] m_imm,
                                  output logic [1:0] m_code, output logic [31:0] m_word);
        int          s;
        logic [31:0] regs;
        s      = $signed(m_imm);
        m_code = 2'b00;
        regs   = 32'(m_op) | (32'(m_f3) << 12) | (32'(m_rs1) << 15);
        case (m_op)
            7'b0110011: m_word = regs | (32'(m_rd) << 7) | (32'(m_rs2) << 20) | (32'(m_f7) << 25);
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (m_op == 7'b0010011 && (m_f3 == 3'd1 || m_f3 == 3'd5)) begin
                    if (m_imm > 32'd31) m_code = 2'b10;
                    m_word = regs | (32'(m_rd) << 7) | ((m_imm & 32'd31) << 20) | (32'(m_f7) << 25);
                end else begin
                    if (s < -2048 || s > 2047) m_code = 2'b10;
                    m_word = regs | (32'(m_rd) << 7) | ((m_imm & 32'hfff) << 20);
                end
            end
            7'b0100011: begin
                if (s < -2048 || s > 2047) m_code = 2'b10;
                m_word = regs | ((m_imm & 32'd31) << 7) | (32'(m_rs2) << 20)
                       | (((m_imm >> 5) & 32'd127) << 25);
            end
            7'b1100011: begin
                if (m_imm[0]) m_code = 2'b11;
                else if (s < -4096 || s > 4095) m_code = 2'b10;
                m_word = regs | (((m_imm >> 11) & 32'd1) << 7) | (((m_imm >> 1) & 32'd15) << 8)
                       | (32'(m_rs2) << 20) | (((m_imm >> 5) & 32'd63) << 25)
                       | (((m_imm >> 12) & 32'd1) << 31);
            end
            7'b1101111: begin
                if (m_imm[0]) m_code = 2'b11;
                else if (s < -(1 << 20) || s > (1 << 20) - 1) m_code = 2'b10;
                m_word = 32'(m_op) | (32'(m_rd) << 7) | (((m_imm >> 12) & 32'd255) << 12)
                       | (((m_imm >> 11) & 32'd1) << 20) | (((m_imm >> 1) & 32'd1023) << 21)
                       | (((m_imm >> 20) & 32'd1) << 31);
            end
            7'b0010111: begin
                if ((m_imm % 32'd4096) != 0) m_code = 2'b10;
                m_word = 32'(m_op) | (32'(m_rd) << 7) | (m_imm & 32'hfffff000);
            end
            default: begin
                m_code = 2'b01;
                m_word = '0;
            end
        endcase
    endfunction

    task automatic push_expect();
        logic [1:0]  c;
        logic [31:0] w;
        model(op, rd, rs1, rs2, funct3, funct7, imm, c, w);
        if (c == 2'b00) begin
            exp_q.push_back(w);
        end else begin
            err_q.push_back(c);
            model_err++;
        end
    endtask

    task automatic set_req(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] i);
        op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = i;
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] i);
        bit done;
        done = 1'b0;
        set_req(o, d, s1, s2, f3, f7, i);
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                push_expect();
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_expect(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] i,
                               input string name, input logic [31:0] exp);
        send(o, d, s1, s2, f3, 7'd0, i);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check(name, out_instr, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send_err(input logic [6:0] o, input logic [31:0] i, input logic [2:0] f3,
                            input string name, input logic [1:0] exp);
        send(o, 5'd1, 5'd2, 5'd3, f3, 7'd0, i);
        @(negedge clk);
        check({name, "_err_valid"}, 32'(err_valid), 32'd1);
        check({name, "_err_code"}, 32'(err_code), 32'(exp));
        check({name, "_no_out"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(err_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_emit_count"}, 32'(emit_count), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Monitor: every output or error handshake is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                model_emit++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h expected no output", out_instr);
                end else begin
                    check("sb_out_instr", out_instr, exp_q.pop_front());
                end
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_error: got code %0d expected no error", err_code);
                end else begin
                    check("sb_err_code", 32'(err_code), 32'(err_q.pop_front()));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    logic [6:0]  op_tab  [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b0010111, 7'b0110111, 7'b1110011};
    logic [31:0] imm_tab [16] = '{32'd0, 32'd1, 32'd31, 32'd32, 32'd2047, 32'd2048,
                                  32'hfffff800, 32'hfffff7ff, 32'd4094, 32'd4096,
                                  32'hfffff000, 32'hffffefff, 32'h000ffffe, 32'h00100000,
                                  32'hfff00000, 32'h12345000};

    initial begin
        int t;
        reset = 1'b1;
        in_valid = 1'b0;
        set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // addi x1, x0, 5 with latency-1 check and emit count after the pop
        send_expect(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, "addi", 32'h00500093);
        @(negedge clk);
        check("emit_after_addi", 32'(emit_count), 32'd1);
        @(posedge clk);
        #1;

        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        @(negedge clk);
        check("add", out_instr, 32'h002081b3);
        @(posedge clk);
        #1;
        send_expect(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, "sw", 32'h0020a423);
        send_expect(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hfffffffc, "beq", 32'hfe000ee3);
        send_expect(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h00000800, "jal", 32'h001000ef);

        send_err(7'b1100011, 32'd3, 3'b000, "b_misalign", 2'b11);
        send_err(7'b0110111, 32'd0, 3'b000, "bad_opcode", 2'b01);
        send_err(7'b0010011, 32'd2048, 3'b000, "i_range", 2'b10);
        check("err_count_3", 32'(err_count), 32'd3);

        // Backpressure: two fill the buffer, the third waits for the first pop
        fixed_ready = 1'b0;
        send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd10);
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'd11);
        set_req(7'b0010011, 5'd6, 5'd0, 5'd0, 3'b000, 7'd0, 32'd12);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        @(negedge clk);
        check("bp_no_comb_ready", 32'(in_ready), 32'd0);
        check("bp_head", out_instr, 32'h00a00213);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        if (in_ready) push_expect();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two words buffered discards them
        fixed_ready = 1'b0;
        send(7'b0010011, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
        send(7'b0010011, 5'd8, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        err_q.delete();
        model_emit = 0;
        model_err = 0;
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        send_expect(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, "post_reset_sw", 32'h0020a423);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: imm = $urandom();
                1: begin
                    t = int'($urandom_range(0, 8191)) - 4096;
                    imm = 32'(t);
                end
                2: imm = imm_tab[$urandom_range(0, 15)];
                default: imm = 32'($urandom_range(0, 40));
            endcase
            send(op_tab[$urandom_range(0, 9)], 5'($urandom()), 5'($urandom()), 5'($urandom()),
                 3'($urandom()), 7'($urandom()), imm);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("final_words_left", 32'(exp_q.size()), 32'd0);
        check("final_errs_left", 32'(err_q.size()), 32'd0);
        check("final_emit_count", 32'(emit_count), 32'(model_emit));
        check("final_err_count", 32'(err_count), 32'(model_err));
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
